// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared definitions for the two-master byte-memory arbiter:
//   - access size encodings (byte/half/word/dword)
//   - FSM state encoding
//   - bytes_for_size(): number of byte transfers for an access size
// Optional feature macro used by importers: MEMBUS_ALIGN_CHECK_EN.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // 1 << size: 1, 2, 4 or 8 byte transfers.
    function automatic logic [3:0] bytes_for_size(input size_e size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   One master's request/response bundle toward the arbiter.
//   Signals: req, we, size, is_signed, addr, wdata (master -> arbiter);
//            done, rdata (arbiter -> master).
//   Modports: master (the requesting side), slave (the arbiter side).
//
// Handshake: the master raises req with we/size/is_signed/addr/wdata stable
// and holds them until the one-cycle done pulse. It may drop req in the done
// cycle; a req still high after that cycle is a new request. rdata is valid
// on done and holds until that master's next load completes.
interface mem_bus_arbiter_if #(
    parameter int DATA_W = 64
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              is_signed;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, size, is_signed, addr, wdata,
        input  done, rdata
    );

    modport slave (
        input  req, we, size, is_signed, addr, wdata,
        output done, rdata
    );
endinterface

// File: rtl/mem_load_extend.sv
// mem_load_extend
//   Combinational sign/zero extension of an assembled little-endian load.
//   Ports:
//     raw       in  64  assembled bytes (lane i = byte i of the access)
//     size      in  2   access size (byte/half/word/dword)
//     is_signed in  1   1 = sign-extend from the top byte, 0 = zero-extend
//     ext       out 64  extended result; dword passes through unchanged
module mem_load_extend
    import mem_bus_arbiter_pkg::*;
(
    input  logic [63:0] raw,
    input  size_e       size,
    input  logic        is_signed,
    output logic [63:0] ext
);

    always_comb begin
        ext = raw;
        case (size)
            SIZE_BYTE: ext = {{56{is_signed & raw[7]}},  raw[7:0]};
            SIZE_HALF: ext = {{48{is_signed & raw[15]}}, raw[15:0]};
            SIZE_WORD: ext = {{32{is_signed & raw[31]}}, raw[31:0]};
            default:   ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares a byte-wide synchronous single-port memory between two 64-bit
//   masters (m0 = CPU load/store, m1 = loader/debug). Round-robin grant,
//   each 1/2/4/8-byte access is serialized into little-endian byte
//   transfers, loads are sign/zero-extended and a one-cycle done pulse goes
//   back to the granted master.
//   Ports:
//     clk, rst          clock; asynchronous active-high reset
//     m0, m1            mem_bus_arbiter_if.slave request/response bundles
//     err               misalignment flag, pulses with done
//     busy              FSM not in IDLE
//     owner             master currently or last granted (1 after reset)
//     mem_addr/re/we/wdata/rdata  byte memory port (1-cycle read latency)
//     state_dbg         current FSM state
//   Optional: `define MEMBUS_ALIGN_CHECK_EN to answer misaligned requests
//   with done+err and no memory traffic; otherwise err is tied to 0.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.slave  m0,
    mem_bus_arbiter_if.slave  m1,
    output logic              err,
    output logic              busy,
    output logic              owner,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output state_e            state_dbg
);

    state_e              state_q, state_d;
    logic                we_q, sgn_q, owner_q;
    size_e               size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [2:0]          cnt_q;
    logic [63:0]         asm_q;
    logic [1:0]          done_q;
    logic [DATA_W-1:0]   rdata0_q, rdata1_q;
    logic [63:0]         ext_data;

    // Grant selection and the fields of the master being granted.
    logic                req_any, grant_m1;
    logic                g_we, g_sgn, g_mis;
    size_e               g_size;
    logic [ADDR_W-1:0]   g_addr;
    logic [DATA_W-1:0]   g_wdata;

    logic [3:0]          n_bytes;
    logic                last_byte;
    logic [2:0]          cap_lane;
    logic                mis_q;

    assign req_any  = m0.req | m1.req;
    // Exactly one requester wins outright; on contention the master that
    // was not granted last time goes next.
    assign grant_m1 = m1.req & (~m0.req | ~owner_q);

    assign g_we    = grant_m1 ? m1.we        : m0.we;
    assign g_sgn   = grant_m1 ? m1.is_signed : m0.is_signed;
    assign g_size  = size_e'(grant_m1 ? m1.size : m0.size);
    assign g_addr  = grant_m1 ? m1.addr[ADDR_W-1:0] : m0.addr[ADDR_W-1:0];
    assign g_wdata = grant_m1 ? m1.wdata     : m0.wdata;

    assign n_bytes   = bytes_for_size(size_q);
    assign last_byte = ({1'b0, cnt_q} == (n_bytes - 4'd1));
    // Read data arrives one cycle after its strobe, so the lane being
    // captured trails the counter by one (wraps to 7 after a dword).
    assign cap_lane  = cnt_q - 3'd1;

    logic unused_addr_hi;
    assign unused_addr_hi = ^{m0.addr[DATA_W-1:ADDR_W], m1.addr[DATA_W-1:ADDR_W]};

`ifdef MEMBUS_ALIGN_CHECK_EN
    logic err_q;

    assign g_mis = (g_addr[2:0] & 3'(bytes_for_size(g_size) - 4'd1)) != 3'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && req_any) begin
                mis_q <= g_mis;
            end
            err_q <= (state_q == ST_RESP) & mis_q;
        end
    end

    assign err = err_q;
`else
    assign g_mis = 1'b0;
    assign mis_q = 1'b0;
    assign err   = 1'b0;
`endif

    mem_load_extend u_extend (
        .raw       (asm_q),
        .size      (size_q),
        .is_signed (sgn_q),
        .ext       (ext_data)
    );

    // Next state and memory strobes.
    always_comb begin
        state_d = state_q;
        mem_re  = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    state_d = g_mis ? ST_RESP : ST_XFER;
                end
            end
            ST_XFER: begin
                mem_we = we_q;
                mem_re = ~we_q;
                if (last_byte) begin
                    state_d = we_q ? ST_RESP : ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch, byte counter, load assembly and responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            sgn_q    <= 1'b0;
            size_q   <= SIZE_BYTE;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= 3'd0;
            asm_q    <= 64'd0;
            owner_q  <= 1'b1;
            done_q   <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            done_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (req_any) begin
                        owner_q <= grant_m1;
                        we_q    <= g_we;
                        sgn_q   <= g_sgn;
                        size_q  <= g_size;
                        addr_q  <= g_addr;
                        wdata_q <= g_wdata;
                        cnt_q   <= 3'd0;
                        asm_q   <= 64'd0;
                    end
                end
                ST_XFER: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (!we_q && cnt_q != 3'd0) begin
                        asm_q[{cap_lane, 3'b000} +: 8] <= mem_rdata;
                    end
                end
                ST_DRAIN: begin
                    asm_q[{cap_lane, 3'b000} +: 8] <= mem_rdata;
                end
                ST_RESP: begin
                    done_q[owner_q] <= 1'b1;
                    if (!we_q && !mis_q) begin
                        if (owner_q) rdata1_q <= ext_data;
                        else         rdata0_q <= ext_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address wraps modulo 2^ADDR_W through the natural adder width.
    assign mem_addr  = addr_q + ADDR_W'(cnt_q);
    assign mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];

    assign m0.done   = done_q[0];
    assign m1.done   = done_q[1];
    assign m0.rdata  = rdata0_q;
    assign m1.rdata  = rdata1_q;
    assign busy      = (state_q != ST_IDLE);
    assign owner     = owner_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Self-checking bench for mem_bus_arbiter. A byte memory model sits on the
//   memory port; a reference model built from the access rules (byte lists,
//   arithmetic extension, round-robin by last owner) predicts write traffic,
//   load results, latency and err. Honours MEMBUS_ALIGN_CHECK_EN.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.DATA_W(64)) m0_if ();
  mem_bus_arbiter_if #(.DATA_W(64)) m1_if ();

  logic        err, busy, owner;
  logic [11:0] mem_addr;
  logic        mem_re, mem_we;
  logic [7:0]  mem_wdata, mem_rdata;
  state_e      state_dbg;

  mem_bus_arbiter #(.ADDR_W(12), .DATA_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .err       (err),
    .busy      (busy),
    .owner     (owner),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- memory + monitors ----------------
  logic [7:0]  mem [4096];
  logic [19:0] wr_q[$];      // observed writes {addr, byte}
  int          re_count = 0;
  int          done_cnt0 = 0, done_cnt1 = 0, both_done_cnt = 0;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (!rst && mem_we) begin
      mem[mem_addr] = mem_wdata;
      wr_q.push_back({mem_addr, mem_wdata});
    end
    if (!rst && mem_re) re_count++;
  end

  always @(negedge clk) begin
    if (m0_if.done) done_cnt0++;
    if (m1_if.done) done_cnt1++;
    if (m0_if.done && m1_if.done) both_done_cnt++;
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [4096];
  logic [63:0] exp_rdata [2];
  logic        ref_owner;
  logic [19:0] exp_q[$];     // expected writes {addr, byte}

  task automatic model_op(input int mst, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [63:0] addr, input logic [63:0] wdata,
                          output int exp_lat, output logic exp_err);
    int          n;
    int          a;
    int          ai;
    logic        mis;
    logic [63:0] v;
    n = 1 << size;
    a = int'(addr[11:0]);
`ifdef MEMBUS_ALIGN_CHECK_EN
    mis = (a % n) != 0;
`else
    mis = 1'b0;
`endif
    ref_owner = mst[0];
    exp_err   = mis;
    if (mis) begin
      exp_lat = 1;
    end else if (we) begin
      for (int i = 0; i < n; i++) begin
        ai = (a + i) % 4096;
        ref_mem[ai] = wdata[8*i +: 8];
        exp_q.push_back({12'(ai), wdata[8*i +: 8]});
      end
      exp_lat = n + 1;
    end else begin
      v = 64'd0;
      for (int i = 0; i < n; i++) v = v | (64'(ref_mem[(a + i) % 4096]) << (8*i));
      if (sgn && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
      exp_rdata[mst] = v;
      exp_lat = n + 2;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int mst, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [63:0] addr, input logic [63:0] wdata);
    if (mst == 0) begin
      m0_if.we = we; m0_if.size = size; m0_if.is_signed = sgn;
      m0_if.addr = addr; m0_if.wdata = wdata; m0_if.req = 1'b1;
    end else begin
      m1_if.we = we; m1_if.size = size; m1_if.is_signed = sgn;
      m1_if.addr = addr; m1_if.wdata = wdata; m1_if.req = 1'b1;
    end
  endtask

  // Called at a negedge with the arbiter idle; returns cycles from the
  // accepting edge to done, and err as seen in the done cycle.
  task automatic do_op(input int mst, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [63:0] addr, input logic [63:0] wdata,
                       output int lat, output logic err_seen);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    drive_req(mst, we, size, sgn, addr, wdata);
    while (!got && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      got = (mst == 0) ? m0_if.done : m1_if.done;
    end
    err_seen = err;
    if (mst == 0) m0_if.req = 1'b0; else m1_if.req = 1'b0;
    lat = cyc - 1;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL op_timeout m%0d: no done within %0d cycles, required done", mst, cyc);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (owner !== 1'b1) begin n_fail++; $display("FAIL reset_owner: got %b want 1", owner); end
    n_checks++; if ({mem_re, mem_we} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {mem_re, mem_we}); end
    n_checks++; if ({mem_addr, mem_wdata} !== 20'd0) begin n_fail++; $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata}); end
    n_checks++; if ({m0_if.done, m1_if.done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_done_err: got %b want 000", {m0_if.done, m1_if.done, err}); end
    n_checks++; if ({m0_if.rdata, m1_if.rdata} !== 128'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", {m0_if.rdata, m1_if.rdata}); end
    rst = 1'b0;
    ref_owner = 1'b1;
    exp_rdata[0] = 64'd0;
    exp_rdata[1] = 64'd0;
  endtask

  task automatic test_round_robin();
    int   order[$];
    int   cyc;
    int   both0;
    int   e;
    int   el;
    logic ee;
    bit   bad;
    wr_q.delete(); exp_q.delete();
    both0 = both_done_cnt;
    drive_req(0, 1'b1, 2'd2, 1'b0, 64'h100, 64'h0000_0000_CAFE_0000);
    drive_req(1, 1'b1, 2'd2, 1'b0, 64'h200, 64'h0000_0000_BEEF_1111);
    cyc = 0;
    while (order.size() < 4 && cyc < 100) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (m0_if.done) order.push_back(0);
      if (m1_if.done) order.push_back(1);
      if (order.size() >= 4) begin m0_if.req = 1'b0; m1_if.req = 1'b0; end
    end
    m0_if.req = 1'b0; m1_if.req = 1'b0;
    n_checks++;
    if (order.size() != 4) begin n_fail++; $display("FAIL rr_count: got %0d dones want 4", order.size()); end
    e = ref_owner ? 0 : 1;
    for (int k = 0; k < 4; k++) begin
      if (e == 0) model_op(0, 1'b1, 2'd2, 1'b0, 64'h100, 64'h0000_0000_CAFE_0000, el, ee);
      else        model_op(1, 1'b1, 2'd2, 1'b0, 64'h200, 64'h0000_0000_BEEF_1111, el, ee);
      if (k < order.size()) begin
        n_checks++;
        if (order[k] != e) begin n_fail++; $display("FAIL rr_order[%0d]: got m%0d want m%0d", k, order[k], e); end
      end
      e = 1 - e;
    end
    #1;
    n_checks++; if (both_done_cnt != both0) begin n_fail++; $display("FAIL rr_both_done: got %0d want %0d", both_done_cnt - both0, 0); end
    bad = (wr_q.size() != exp_q.size());
    if (!bad) foreach (exp_q[k]) if (wr_q[k] !== exp_q[k]) bad = 1'b1;
    n_checks++; if (bad) begin n_fail++; $display("FAIL rr_writes: got %0d writes want %0d matching", wr_q.size(), exp_q.size()); end
  endtask

  task automatic test_store_load_dword();
    int   lat, el;
    logic es, ee;
    bit   bad;
    wr_q.delete(); exp_q.delete();
    model_op(0, 1'b1, 2'd3, 1'b0, 64'h010, 64'h1122334455667788, el, ee);
    do_op(0, 1'b1, 2'd3, 1'b0, 64'h010, 64'h1122334455667788, lat, es);
    n_checks++; if (lat != 9) begin n_fail++; $display("FAIL dword_store_lat: got %0d want 9", lat); end
    bad = (wr_q.size() != 8);
    for (int i = 0; i < 8 && !bad; i++)
      if (wr_q[i] !== {12'h010 + 12'(i), 8'h88 - 8'(i * 8'h11)}) bad = 1'b1;
    n_checks++; if (bad) begin n_fail++; $display("FAIL dword_store_bytes: got %0d writes, first %h, want 010:88..017:11", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 20'h0); end
    model_op(0, 1'b0, 2'd3, 1'b1, 64'h010, 64'd0, el, ee);
    do_op(0, 1'b0, 2'd3, 1'b1, 64'h010, 64'd0, lat, es);
    n_checks++; if (m0_if.rdata !== 64'h1122334455667788) begin n_fail++; $display("FAIL dword_load_data: got %h want 1122334455667788", m0_if.rdata); end
    n_checks++; if (lat != 10) begin n_fail++; $display("FAIL dword_load_lat: got %0d want 10", lat); end
  endtask

  task automatic test_byte_sign();
    int   lat, el;
    logic es, ee;
    mem[12'h020] = 8'h80;
    ref_mem[12'h020] = 8'h80;
    model_op(1, 1'b0, 2'd0, 1'b1, 64'h020, 64'd0, el, ee);
    do_op(1, 1'b0, 2'd0, 1'b1, 64'h020, 64'd0, lat, es);
    n_checks++; if (m1_if.rdata !== 64'hFFFFFFFFFFFFFF80) begin n_fail++; $display("FAIL byte_signed: got %h want FFFFFFFFFFFFFF80", m1_if.rdata); end
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL byte_load_lat: got %0d want 3", lat); end
    model_op(1, 1'b0, 2'd0, 1'b0, 64'h020, 64'd0, el, ee);
    do_op(1, 1'b0, 2'd0, 1'b0, 64'h020, 64'd0, lat, es);
    n_checks++; if (m1_if.rdata !== 64'h80) begin n_fail++; $display("FAIL byte_unsigned: got %h want 80", m1_if.rdata); end
    n_checks++; if (m0_if.rdata !== exp_rdata[0]) begin n_fail++; $display("FAIL byte_other_rdata: got %h want %h", m0_if.rdata, exp_rdata[0]); end
  endtask

  task automatic test_wrap();
    int   lat, el;
    logic es, ee;
    wr_q.delete(); exp_q.delete();
    model_op(0, 1'b1, 2'd1, 1'b0, 64'hFFF, 64'hBEEF, el, ee);
    do_op(0, 1'b1, 2'd1, 1'b0, 64'hFFF, 64'hBEEF, lat, es);
    n_checks++;
    if (wr_q.size() != 2 || wr_q[0] !== {12'hFFF, 8'hEF} || wr_q[1] !== {12'h000, 8'hBE}) begin
      n_fail++; $display("FAIL wrap_bytes: got %0d writes first %h want FFF:EF then 000:BE", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 20'h0);
    end
  endtask

  task automatic test_align();
    int   lat, el, re0;
    logic es, ee;
    re0 = re_count;
    model_op(1, 1'b0, 2'd2, 1'b0, 64'h002, 64'd0, el, ee);
    do_op(1, 1'b0, 2'd2, 1'b0, 64'h002, 64'd0, lat, es);
    n_checks++; if (lat != el) begin n_fail++; $display("FAIL align_lat: got %0d want %0d", lat, el); end
    n_checks++; if (es !== ee) begin n_fail++; $display("FAIL align_err: got %b want %b", es, ee); end
    n_checks++; if (m1_if.rdata !== exp_rdata[1]) begin n_fail++; $display("FAIL align_rdata: got %h want %h", m1_if.rdata, exp_rdata[1]); end
`ifdef MEMBUS_ALIGN_CHECK_EN
    n_checks++; if (re_count != re0) begin n_fail++; $display("FAIL align_no_re: got %0d reads want 0", re_count - re0); end
`else
    n_checks++; if (re_count - re0 != 4) begin n_fail++; $display("FAIL align_reads: got %0d reads want 4", re_count - re0); end
`endif
  endtask

  task automatic test_reset_mid();
    int   d0, d1, cyc, first, el;
    bit   got0, got1;
    logic ee;
    drive_req(0, 1'b1, 2'd3, 1'b0, 64'h300, 64'hA1A2A3A4A5A6A7A8);
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 12'h303) begin n_fail++; $display("FAIL rstmid_byte3: got we=%b addr=%h want we=1 addr=303", mem_we, mem_addr); end
    rst = 1'b1;
    #1;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_we: got %b want 0", mem_we); end
    n_checks++; if (busy !== 1'b0 || owner !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_owner: got %b%b want 01", busy, owner); end
    m0_if.req = 1'b0;
    d0 = done_cnt0; d1 = done_cnt1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    n_checks++; if (done_cnt0 != d0 || done_cnt1 != d1) begin n_fail++; $display("FAIL rstmid_no_done: got %0d dones want 0", (done_cnt0 - d0) + (done_cnt1 - d1)); end
    // Bytes 0..2 landed before reset and stay written.
    ref_mem[12'h300] = 8'hA8; ref_mem[12'h301] = 8'hA7; ref_mem[12'h302] = 8'hA6;
    ref_owner = 1'b1; exp_rdata[0] = 64'd0; exp_rdata[1] = 64'd0;
    @(negedge clk);
    model_op(0, 1'b0, 2'd0, 1'b0, 64'h302, 64'd0, el, ee);
    model_op(1, 1'b0, 2'd0, 1'b0, 64'h303, 64'd0, el, ee);
    drive_req(0, 1'b0, 2'd0, 1'b0, 64'h302, 64'd0);
    drive_req(1, 1'b0, 2'd0, 1'b0, 64'h303, 64'd0);
    first = -1; got0 = 1'b0; got1 = 1'b0; cyc = 0;
    while (!(got0 && got1) && cyc < 60) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (m0_if.done) begin got0 = 1'b1; m0_if.req = 1'b0; if (first < 0) first = 0; end
      if (m1_if.done) begin got1 = 1'b1; m1_if.req = 1'b0; if (first < 0) first = 1; end
    end
    m0_if.req = 1'b0; m1_if.req = 1'b0;
    n_checks++; if (first != 0) begin n_fail++; $display("FAIL rstmid_first_grant: got m%0d want m0", first); end
    n_checks++; if (m0_if.rdata !== exp_rdata[0]) begin n_fail++; $display("FAIL rstmid_m0_rdata: got %h want %h", m0_if.rdata, exp_rdata[0]); end
    n_checks++; if (m1_if.rdata !== exp_rdata[1]) begin n_fail++; $display("FAIL rstmid_m1_rdata: got %h want %h", m1_if.rdata, exp_rdata[1]); end
  endtask

  task automatic test_random();
    int          mst, lat, el;
    logic        we, sgn, es, ee;
    logic [1:0]  size;
    logic [63:0] addr, wdata;
    bit          bad;
    for (int t = 0; t < 30; t++) begin
      mst   = int'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      sgn   = 1'($urandom_range(0, 1));
      addr  = ($urandom_range(0, 3) == 0) ? 64'(12'hFFF - 12'($urandom_range(0, 6))) : {$urandom, $urandom};
      wdata = {$urandom, $urandom};
      wr_q.delete(); exp_q.delete();
      model_op(mst, we, size, sgn, addr, wdata, el, ee);
      do_op(mst, we, size, sgn, addr, wdata, lat, es);
      n_checks++; if (lat != el) begin n_fail++; $display("FAIL rand_lat[%0d]: got %0d want %0d", t, lat, el); end
      n_checks++; if (es !== ee) begin n_fail++; $display("FAIL rand_err[%0d]: got %b want %b", t, es, ee); end
      n_checks++; if (m0_if.rdata !== exp_rdata[0]) begin n_fail++; $display("FAIL rand_m0_rdata[%0d]: got %h want %h", t, m0_if.rdata, exp_rdata[0]); end
      n_checks++; if (m1_if.rdata !== exp_rdata[1]) begin n_fail++; $display("FAIL rand_m1_rdata[%0d]: got %h want %h", t, m1_if.rdata, exp_rdata[1]); end
      bad = (wr_q.size() != exp_q.size());
      if (!bad) foreach (exp_q[k]) if (wr_q[k] !== exp_q[k]) bad = 1'b1;
      n_checks++; if (bad) begin n_fail++; $display("FAIL rand_writes[%0d]: got %0d writes want %0d matching", t, wr_q.size(), exp_q.size()); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    logic [7:0] r;
    for (int i = 0; i < 4096; i++) begin
      r = 8'($urandom);
      mem[i] = r;
      ref_mem[i] = r;
    end
    m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.size = 2'd0; m0_if.is_signed = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.size = 2'd0; m1_if.is_signed = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;
    test_reset();
    test_round_robin();
    test_store_load_dword();
    test_byte_sign();
    test_wrap();
    test_align();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one byte-wide, single-port data memory between two 64-bit masters: m0 is the CPU load/store port, m1 is the loader/debug port.
- Arbitrates round-robin.
- Serializes each 1/2/4/8-byte access into little-endian byte transfers.
- Sign- or zero-extends load data, then returns a one-cycle done pulse to the granted master.

Parameters:
ADDR_W, 12, memory byte-address width; all byte addresses wrap modulo 2^ADDR_W
DATA_W, 64, master data width (matches core BIT_WIDTH)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-high
m0_req  input  1  m0 request; held high with fields stable until m0_done
m0_we  input  1  1 = store, 0 = load
m0_size  input  2  0 = byte, 1 = half, 2 = word, 3 = dword
m0_signed  input  1  load extension: 1 = sign, 0 = zero; ignored for stores
m0_addr  input  DATA_W  byte address; only [ADDR_W-1:0] used
m0_wdata  input  DATA_W  store data; low 8<<size bits used
m0_done  output  1  one-cycle completion pulse
m0_rdata  output  DATA_W  extended load data; valid on m0_done, held until m0's next load completes
m1_req, m1_we, m1_size, m1_signed, m1_addr, m1_wdata, m1_done, m1_rdata  same as m0_*, for m1
err  output  1  misalignment flag, coincident with a done pulse (see Optional Feature)
busy  output  1  high when the FSM is not in IDLE
owner  output  1  master currently or last granted
mem_addr  output  ADDR_W  byte address to memory
mem_re  output  1  read strobe; mem_rdata is valid the cycle after mem_re
mem_we  output  1  write strobe; byte written at the clock edge
mem_wdata  output  8  write byte
mem_rdata  input  8  read byte (synchronous memory, 1-cycle latency)

Behaviour:
- States: IDLE, XFER, DRAIN, RESP.
- Reset values:
  - state = IDLE.
  - All done outputs, err, busy, mem_re and mem_we = 0.
  - mem_addr, mem_wdata, both rdata outputs, byte counter and assembly register = 0.
  - owner = 1, so m0 wins the first contention.
- Reset mid-transfer aborts it:
  - No done pulse is produced.
  - The partial write is not rolled back.
- IDLE:
  - Sample requests.
  - If exactly one master requests, grant it.
  - If both request, grant !owner.
  - On grant: latch we/size/signed/addr/wdata; set owner = granted master, N = 1<<size, i = 0; go to XFER.
- XFER, one byte per cycle, for i = 0..N-1:
  - mem_addr = (addr + i) mod 2^ADDR_W.
  - Store: mem_we = 1, mem_wdata = wdata[8i+7:8i].
  - Load: mem_re = 1; mem_rdata captured in the following cycle into byte lane i.
  - After byte N-1: a store goes to RESP; a load goes to DRAIN.
- DRAIN (loads only):
  - Capture the last byte; no memory strobe.
  - Go to RESP.
- RESP:
  - Pulse the owner's done for exactly one cycle.
  - For loads, update the owner's rdata with the extended value. The other master's rdata is unchanged.
  - Go to IDLE.
- Extension: bits above 8N are filled with byte N-1 bit 7 if signed, else zero. Dword ignores signed.
- Latency from the request-sampled edge: store done after N+1 cycles; load done after N+2 cycles. Example: a dword load gives done 10 cycles after acceptance.
- Master handshake:
  - The master may drop req in the cycle done is high.
  - A req still high in the cycle after RESP is a new request.
  - Back-to-back requests from the same master lose to a pending other master (round-robin fairness).
- req deasserted mid-transfer by a misbehaving master is ignored; the transfer completes.
- Address wrap-around: 0xFFF + 1 rolls to 0x000 inside a multi-byte access.

Optional Feature:
- Macro: MEMBUS_ALIGN_CHECK_EN.
- Defined:
  - A request is misaligned when addr mod N != 0.
  - A misaligned request is granted normally, then goes IDLE -> RESP directly, with no memory strobes.
  - done and err pulse together; rdata is unchanged.
- Not defined:
  - Misaligned accesses proceed byte-serially.
  - err is tied to 0.

Decomposition:
- Shared package holds:
  - SIZE_BYTE/HALF/WORD/DWORD encodings
  - FSM state constants
  - a bytes-for-size function (1<<size)
- One sub-module: mem_load_extend (combinational).
  - Inputs: 64-bit assembled bytes, size, signed.
  - Output: 64-bit extended result.
- Arbitration, FSM and counters stay in mem_bus_arbiter.

Test Plan:
- m0 dword store of 0x1122334455667788 at 0x010, then m0 signed dword load at 0x010:
  - store: mem_we on addresses 0x010..0x017 with bytes 88,77,66,55,44,33,22,11;
  - store done 9 cycles after accept;
  - load: m0_rdata = 0x1122334455667788.
- Memory byte 0x80 at 0x020, m1 byte load:
  - signed=1 -> m1_rdata = 0xFFFFFFFFFFFFFF80;
  - signed=0 -> m1_rdata = 0x80;
  - done 3 cycles after accept.
- m0 and m1 both requesting a word store, held continuously through 4 transactions:
  - grant order m0, m1, m0, m1;
  - done never asserted for both masters in the same cycle.
- m0 half store of 0xBEEF at 0xFFF: bytes EF -> 0xFFF, BE -> 0x000.
- Assert rst during XFER of a dword store (byte 3):
  - mem_we = 0 immediately;
  - no done pulse;
  - owner = 1 after release;
  - next contention grants m0.
- With MEMBUS_ALIGN_CHECK_EN defined, m1 word load at 0x002: done and err pulse 1 cycle after accept, no mem_re, m1_rdata unchanged. Without the macro: normal 6-cycle load, err = 0.
